// File: rtl/sdram_arbiter_if.sv
// Bundle of requester-side and SDRAM-controller-side signals around sdram_arbiter.
// master: the arbiter's view; slave: the surrounding front-end and controller.
interface sdram_arbiter_if;
   logic        vid_req;
   logic [23:0] vid_addr;
   logic [10:0] vid_len;
   logic        vid_busy;
   logic        vid_valid;
   logic [31:0] vid_data;
   logic        vid_done;
   logic        hrd_req;
   logic [23:0] hrd_addr;
   logic        hrd_ack;
   logic [31:0] hrd_data;
   logic        hwr_req;
   logic [23:0] hwr_addr;
   logic [31:0] hwr_data;
   logic [3:0]  hwr_be;
   logic        hwr_ack;
   logic        cmd_ready;
   logic        cmd_enable;
   logic        cmd_wr;
   logic [3:0]  cmd_byte_enable;
   logic [23:0] cmd_address;
   logic [31:0] cmd_data_in;
   logic [31:0] data_out;
   logic        data_out_ready;
   logic [1:0]  grant;

   modport master (
      input  vid_req, vid_addr, vid_len, hrd_req, hrd_addr,
      input  hwr_req, hwr_addr, hwr_data, hwr_be,
      input  cmd_ready, data_out, data_out_ready,
      output vid_busy, vid_valid, vid_data, vid_done, hrd_ack, hrd_data, hwr_ack,
      output cmd_enable, cmd_wr, cmd_byte_enable, cmd_address, cmd_data_in, grant
   );

   modport slave (
      output vid_req, vid_addr, vid_len, hrd_req, hrd_addr,
      output hwr_req, hwr_addr, hwr_data, hwr_be,
      output cmd_ready, data_out, data_out_ready,
      input  vid_busy, vid_valid, vid_data, vid_done, hrd_ack, hrd_data, hwr_ack,
      input  cmd_enable, cmd_wr, cmd_byte_enable, cmd_address, cmd_data_in, grant
   );
endinterface

// File: rtl/sdram_arbiter.sv
// Single-outstanding-command arbiter: host read > video burst > write, video pre-emptible per slice.
// Optional write starvation guard enabled by defining ARB_STARVE_GUARD_EN.
module sdram_arbiter #(
   parameter int VID_SLICE  = 16,
   parameter int STARVE_MAX = 64
) (
   input  logic           z_sample_clk,
   input  logic           znRST,
   sdram_arbiter_if.master bus
);
   typedef enum logic [1:0] {IDLE, RD_WAIT, GAP} state_t;

   localparam logic [1:0]  G_NONE    = 2'd0;
   localparam logic [1:0]  G_VID     = 2'd1;
   localparam logic [1:0]  G_HRD     = 2'd2;
   localparam logic [1:0]  G_HWR     = 2'd3;
   localparam logic [15:0] SLICE_LIM = 16'(VID_SLICE);

   state_t      state_q, state_d;
   logic [1:0]  grant_q, grant_d;
   logic        cmd_enable_q, cmd_enable_d;
   logic        cmd_wr_q, cmd_wr_d;
   logic [3:0]  cmd_be_q, cmd_be_d;
   logic [23:0] cmd_addr_q, cmd_addr_d;
   logic [31:0] cmd_data_q, cmd_data_d;
   logic        vid_busy_q, vid_busy_d;
   logic        vid_valid_q, vid_valid_d;
   logic [31:0] vid_data_q, vid_data_d;
   logic        vid_done_q, vid_done_d;
   logic        hrd_ack_q, hrd_ack_d;
   logic [31:0] hrd_data_q, hrd_data_d;
   logic        hwr_ack_q, hwr_ack_d;
   logic [23:0] vid_ptr_q, vid_ptr_d;
   logic [10:0] vid_rem_q, vid_rem_d;
   logic [15:0] slice_cnt_q, slice_cnt_d;

   logic starve_promote;
   logic vid_active;
   logic host_ok;

`ifdef ARB_STARVE_GUARD_EN
   localparam logic [15:0] STARVE_LIM = 16'(STARVE_MAX);
   logic [15:0] starve_cnt_q, starve_cnt_d;

   always_ff @(posedge z_sample_clk or negedge znRST) begin
      if (!znRST) starve_cnt_q <= '0;
      else        starve_cnt_q <= starve_cnt_d;
   end

   always_comb begin
      starve_cnt_d = starve_cnt_q;
      if (hwr_ack_d)
         starve_cnt_d = '0;
      else if (bus.hwr_req && (starve_cnt_q < STARVE_LIM))
         starve_cnt_d = starve_cnt_q + 16'd1;
   end

   assign starve_promote = bus.hwr_req && (starve_cnt_q >= STARVE_LIM);
`else
   assign starve_promote = 1'b0;
`endif

   // A host read may only cut into a running burst once the slice quota is used up.
   assign vid_active = vid_busy_q && (vid_rem_q != 11'd0);
   assign host_ok    = bus.hrd_req && (!vid_active || (slice_cnt_q >= SLICE_LIM));

   always_ff @(posedge z_sample_clk or negedge znRST) begin
      if (!znRST) begin
         state_q      <= IDLE;
         grant_q      <= G_NONE;
         cmd_enable_q <= 1'b0;
         cmd_wr_q     <= 1'b0;
         cmd_be_q     <= '0;
         cmd_addr_q   <= '0;
         cmd_data_q   <= '0;
         vid_busy_q   <= 1'b0;
         vid_valid_q  <= 1'b0;
         vid_data_q   <= '0;
         vid_done_q   <= 1'b0;
         hrd_ack_q    <= 1'b0;
         hrd_data_q   <= '0;
         hwr_ack_q    <= 1'b0;
         vid_ptr_q    <= '0;
         vid_rem_q    <= '0;
         slice_cnt_q  <= '0;
      end else begin
         state_q      <= state_d;
         grant_q      <= grant_d;
         cmd_enable_q <= cmd_enable_d;
         cmd_wr_q     <= cmd_wr_d;
         cmd_be_q     <= cmd_be_d;
         cmd_addr_q   <= cmd_addr_d;
         cmd_data_q   <= cmd_data_d;
         vid_busy_q   <= vid_busy_d;
         vid_valid_q  <= vid_valid_d;
         vid_data_q   <= vid_data_d;
         vid_done_q   <= vid_done_d;
         hrd_ack_q    <= hrd_ack_d;
         hrd_data_q   <= hrd_data_d;
         hwr_ack_q    <= hwr_ack_d;
         vid_ptr_q    <= vid_ptr_d;
         vid_rem_q    <= vid_rem_d;
         slice_cnt_q  <= slice_cnt_d;
      end
   end

   always_comb begin
      state_d      = state_q;
      grant_d      = grant_q;
      cmd_enable_d = 1'b0;
      cmd_wr_d     = cmd_wr_q;
      cmd_be_d     = cmd_be_q;
      cmd_addr_d   = cmd_addr_q;
      cmd_data_d   = cmd_data_q;
      vid_busy_d   = vid_busy_q;
      vid_valid_d  = 1'b0;
      vid_data_d   = vid_data_q;
      vid_done_d   = 1'b0;
      hrd_ack_d    = 1'b0;
      hrd_data_d   = hrd_data_q;
      hwr_ack_d    = 1'b0;
      vid_ptr_d    = vid_ptr_q;
      vid_rem_d    = vid_rem_q;
      slice_cnt_d  = slice_cnt_q;

      // Busy drops the cycle after the final beat's done pulse.
      if (vid_done_q)
         vid_busy_d = 1'b0;

      if (!vid_busy_q && bus.vid_req) begin
         vid_ptr_d   = bus.vid_addr;
         vid_rem_d   = bus.vid_len;
         slice_cnt_d = '0;
         vid_busy_d  = (bus.vid_len != 11'd0);
         vid_done_d  = (bus.vid_len == 11'd0);
      end

      unique case (state_q)
         IDLE: begin
            if (bus.cmd_ready) begin
               if (starve_promote || (!host_ok && !vid_active && bus.hwr_req)) begin
                  cmd_enable_d = 1'b1;
                  cmd_wr_d     = 1'b1;
                  cmd_be_d     = bus.hwr_be;
                  cmd_addr_d   = bus.hwr_addr;
                  cmd_data_d   = bus.hwr_data;
                  hwr_ack_d    = 1'b1;
                  grant_d      = G_HWR;
                  state_d      = GAP;
               end else if (host_ok) begin
                  cmd_enable_d = 1'b1;
                  cmd_wr_d     = 1'b0;
                  cmd_be_d     = 4'b1111;
                  cmd_addr_d   = bus.hrd_addr;
                  cmd_data_d   = '0;
                  slice_cnt_d  = '0;
                  grant_d      = G_HRD;
                  state_d      = RD_WAIT;
               end else if (vid_active) begin
                  cmd_enable_d = 1'b1;
                  cmd_wr_d     = 1'b0;
                  cmd_be_d     = 4'b1111;
                  cmd_addr_d   = vid_ptr_q;
                  cmd_data_d   = '0;
                  grant_d      = G_VID;
                  state_d      = RD_WAIT;
               end
            end
         end
         RD_WAIT: begin
            if (bus.data_out_ready) begin
               if (grant_q == G_HRD) begin
                  hrd_data_d = bus.data_out;
                  hrd_ack_d  = 1'b1;
               end else begin
                  vid_data_d  = bus.data_out;
                  vid_valid_d = 1'b1;
                  vid_done_d  = (vid_rem_q == 11'd1);
                  vid_ptr_d   = vid_ptr_q + 24'd4;
                  vid_rem_d   = vid_rem_q - 11'd1;
                  slice_cnt_d = (slice_cnt_q >= SLICE_LIM) ? slice_cnt_q : slice_cnt_q + 16'd1;
               end
               state_d = GAP;
            end
         end
         GAP: begin
            grant_d = G_NONE;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   assign bus.grant           = grant_q;
   assign bus.cmd_enable      = cmd_enable_q;
   assign bus.cmd_wr          = cmd_wr_q;
   assign bus.cmd_byte_enable = cmd_be_q;
   assign bus.cmd_address     = cmd_addr_q;
   assign bus.cmd_data_in     = cmd_data_q;
   assign bus.vid_busy        = vid_busy_q;
   assign bus.vid_valid       = vid_valid_q;
   assign bus.vid_data        = vid_data_q;
   assign bus.vid_done        = vid_done_q;
   assign bus.hrd_ack         = hrd_ack_q;
   assign bus.hrd_data        = hrd_data_q;
   assign bus.hwr_ack         = hwr_ack_q;
endmodule

// File: tb/tb_sdram_arbiter.sv
// Scoreboard bench for sdram_arbiter: directed stimulus pushes expectations, a monitor pops them.
// A small controller model answers reads with address-derived data after two cycles.
module tb_sdram_arbiter;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   sdram_arbiter_if bus();

   sdram_arbiter #(.VID_SLICE(16), .STARVE_MAX(64)) dut (
      .z_sample_clk (clk),
      .znRST        (rst_n),
      .bus          (bus)
   );

   typedef struct {
      logic        wr;
      logic [23:0] addr;
      logic [3:0]  be;
      logic [31:0] data;
      logic [1:0]  grant;
   } cmd_t;

   typedef struct {
      logic        valid;
      logic        done;
      logic [31:0] data;
   } vid_t;

   cmd_t        cmd_q[$];
   vid_t        vid_q[$];
   logic [31:0] hrd_q[$];
   cmd_t        wq[$];

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int vid_seen = 0;
   int wr_seen = 0;
   int last_wr_cyc = -100;
   int wr_cyc = 0;
   bit cmd_strict = 1'b1;
   bit busy_chk = 1'b0;

   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [31:0] mem(input logic [23:0] a);
      return {8'hC3, a} ^ 32'h005A_A500;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic cmd_t rd(input logic [23:0] a, input logic [1:0] g);
      cmd_t c;
      c.wr = 1'b0; c.addr = a; c.be = 4'b1111; c.data = 32'h0; c.grant = g;
      return c;
   endfunction

   function automatic cmd_t wrc(input logic [23:0] a, input logic [3:0] be, input logic [31:0] d);
      cmd_t c;
      c.wr = 1'b1; c.addr = a; c.be = be; c.data = d; c.grant = 2'd3;
      return c;
   endfunction

   // expected reads and beats for a burst with no interruption
   task automatic expect_burst(input logic [23:0] base, input int len);
      vid_t v;
      for (int i = 0; i < len; i++) begin
         cmd_q.push_back(rd(base + 24'(4 * i), 2'd1));
         v.valid = 1'b1; v.done = (i == len - 1); v.data = mem(base + 24'(4 * i));
         vid_q.push_back(v);
      end
   endtask

   // controller model: read data two cycles after the command is seen
   int          lat = 0;
   logic [23:0] lat_addr = '0;
   initial begin
      bus.cmd_ready = 1'b1;
      bus.data_out = '0;
      bus.data_out_ready = 1'b0;
      forever begin
         @(negedge clk);
         bus.data_out_ready = 1'b0;
         if (!rst_n) begin
            lat = 0;
         end else begin
            if (lat > 0) begin
               lat--;
               if (lat == 0) begin
                  bus.data_out_ready = 1'b1;
                  bus.data_out = mem(lat_addr);
               end
            end
            if (bus.cmd_enable && !bus.cmd_wr) begin
               lat = 2;
               lat_addr = bus.cmd_address;
            end
         end
      end
   end

   // write queue driver: present the head entry, pop on hwr_ack
   initial begin
      bus.hwr_req = 1'b0; bus.hwr_addr = '0; bus.hwr_data = '0; bus.hwr_be = '0;
      forever begin
         @(negedge clk);
         if (rst_n && bus.hwr_ack && wq.size() > 0) void'(wq.pop_front());
         bus.hwr_req = (wq.size() > 0);
         if (wq.size() > 0) begin
            bus.hwr_addr = wq[0].addr;
            bus.hwr_data = wq[0].data;
            bus.hwr_be   = wq[0].be;
         end
      end
   end

   // monitor
   initial begin
      cmd_t        ec;
      vid_t        ev;
      logic [31:0] eh;
      forever begin
         @(negedge clk);
         if (rst_n) begin
            if (busy_chk) begin
               check("busy_after_done", 32'(bus.vid_busy), 32'd0);
               busy_chk = 1'b0;
            end
            if (bus.cmd_enable) begin
               $display("cmd wr=%0d addr=%06h be=%04b data=%08h grant=%0d", bus.cmd_wr,
                        bus.cmd_address, bus.cmd_byte_enable, bus.cmd_data_in, bus.grant);
               if (bus.cmd_wr) begin
                  wr_seen++;
                  check("wr_spacing", 32'((cyc - last_wr_cyc) >= 2), 32'd1);
                  last_wr_cyc = cyc;
                  wr_cyc = cyc;
               end
               if (cmd_strict) begin
                  if (cmd_q.size() == 0) begin
                     check("cmd_unexpected", 32'(bus.cmd_address), 32'hFFFF_FFFF);
                  end else begin
                     ec = cmd_q.pop_front();
                     check("cmd_wr", 32'(bus.cmd_wr), 32'(ec.wr));
                     check("cmd_addr", 32'(bus.cmd_address), 32'(ec.addr));
                     check("cmd_be", 32'(bus.cmd_byte_enable), 32'(ec.be));
                     check("grant", 32'(bus.grant), 32'(ec.grant));
                     check("hwr_ack", 32'(bus.hwr_ack), 32'(ec.wr));
                     if (ec.wr) check("cmd_data", bus.cmd_data_in, ec.data);
                  end
               end
            end else if (bus.hwr_ack) begin
               check("hwr_ack_stray", 32'(bus.hwr_ack), 32'd0);
            end
            if (bus.vid_valid || bus.vid_done) begin
               $display("vid valid=%0d done=%0d data=%08h", bus.vid_valid, bus.vid_done, bus.vid_data);
               if (bus.vid_valid) vid_seen++;
               if (bus.vid_done) busy_chk = 1'b1;
               if (vid_q.size() == 0) begin
                  check("vid_unexpected", {30'd0, bus.vid_valid, bus.vid_done}, 32'd0);
               end else begin
                  ev = vid_q.pop_front();
                  check("vid_valid", 32'(bus.vid_valid), 32'(ev.valid));
                  check("vid_done", 32'(bus.vid_done), 32'(ev.done));
                  if (ev.valid) check("vid_data", bus.vid_data, ev.data);
               end
            end
            if (bus.hrd_ack) begin
               $display("hrd data=%08h", bus.hrd_data);
               if (hrd_q.size() == 0) begin
                  check("hrd_unexpected", 32'(bus.hrd_ack), 32'd0);
               end else begin
                  eh = hrd_q.pop_front();
                  check("hrd_data", bus.hrd_data, eh);
               end
            end
         end
      end
   end

   task automatic wait_drain(input string name, input int budget);
      int n = 0;
      while ((cmd_q.size() + vid_q.size() + hrd_q.size() + wq.size()) != 0 && n < budget) begin
         @(negedge clk);
         n++;
      end
      repeat (4) @(negedge clk);
      check({"drain_", name}, 32'(n < budget), 32'd1);
   endtask

   task automatic wait_vid(input int target, input int budget);
      int n = 0;
      while (vid_seen < target && n < budget) begin
         @(negedge clk);
         n++;
      end
      check("wait_vid", 32'(n < budget), 32'd1);
   endtask

   task automatic pulse_vid(input logic [23:0] a, input logic [10:0] len);
      @(negedge clk);
      bus.vid_req = 1'b1; bus.vid_addr = a; bus.vid_len = len;
      @(negedge clk);
      bus.vid_req = 1'b0;
   endtask

   initial begin
      vid_t v;
      int   n;
      int   raise_cyc;
      bus.vid_req = 1'b0; bus.vid_addr = '0; bus.vid_len = '0;
      bus.hrd_req = 1'b0; bus.hrd_addr = '0;

      // reset values
      repeat (3) @(negedge clk);
      check("rst_vid_busy", 32'(bus.vid_busy), 32'd0);
      check("rst_cmd_enable", 32'(bus.cmd_enable), 32'd0);
      check("rst_grant", 32'(bus.grant), 32'd0);
      check("rst_vid_done", 32'(bus.vid_done), 32'd0);
      check("rst_hwr_ack", 32'(bus.hwr_ack), 32'd0);
      check("rst_cmd_addr", 32'(bus.cmd_address), 32'd0);
      rst_n = 1'b1;

      // short burst of 4
      vid_seen = 0;
      expect_burst(24'h000000, 4);
      pulse_vid(24'h000000, 11'd4);
      wait_drain("burst4", 200);
      check("burst4_beats", 32'(vid_seen), 32'd4);

      // burst of 40, host read raised at beat 3, pre-empts after beat 16
      vid_seen = 0;
      for (int i = 0; i < 16; i++) cmd_q.push_back(rd(24'(4 * i), 2'd1));
      cmd_q.push_back(rd(24'h200000, 2'd2));
      for (int i = 16; i < 40; i++) cmd_q.push_back(rd(24'(4 * i), 2'd1));
      for (int i = 0; i < 40; i++) begin
         v.valid = 1'b1; v.done = (i == 39); v.data = mem(24'(4 * i));
         vid_q.push_back(v);
      end
      hrd_q.push_back(mem(24'h200000));
      pulse_vid(24'h000000, 11'd40);
      wait_vid(3, 100);
      bus.hrd_addr = 24'h200000;
      bus.hrd_req = 1'b1;
      n = 0;
      while (!bus.hrd_ack && n < 400) begin
         @(negedge clk);
         n++;
      end
      bus.hrd_req = 1'b0;
      check("hrd_ack_seen", 32'(n < 400), 32'd1);
      wait_drain("preempt", 400);
      check("preempt_beats", 32'(vid_seen), 32'd40);

      // back-to-back writes, no other traffic
      wr_seen = 0;
      cmd_q.push_back(wrc(24'h000100, 4'b0101, 32'hABCD1234));
      cmd_q.push_back(wrc(24'h000104, 4'b1010, 32'h55AA55AA));
      @(negedge clk);
      wq.push_back(wrc(24'h000100, 4'b0101, 32'hABCD1234));
      wq.push_back(wrc(24'h000104, 4'b1010, 32'h55AA55AA));
      wait_drain("writes", 100);
      check("writes_issued", 32'(wr_seen), 32'd2);

      // zero-length burst: done one cycle after the request, no command
      v.valid = 1'b0; v.done = 1'b1; v.data = '0;
      vid_q.push_back(v);
      pulse_vid(24'h000500, 11'd0);
      check("len0_done", 32'(bus.vid_done), 32'd1);
      check("len0_busy", 32'(bus.vid_busy), 32'd0);
      wait_drain("len0", 20);

      // reset at beat 5 of 10
      vid_seen = 0;
      expect_burst(24'h000300, 10);
      pulse_vid(24'h000300, 11'd10);
      wait_vid(5, 200);
      @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      check("mid_rst_busy", 32'(bus.vid_busy), 32'd0);
      check("mid_rst_cmd_enable", 32'(bus.cmd_enable), 32'd0);
      check("mid_rst_grant", 32'(bus.grant), 32'd0);
      check("mid_rst_vid_data", bus.vid_data, 32'd0);
      check("mid_rst_vid_valid", 32'(bus.vid_valid), 32'd0);
      cmd_q.delete();
      vid_q.delete();
      busy_chk = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (10) @(negedge clk);
      vid_seen = 0;
      expect_burst(24'h000400, 2);
      pulse_vid(24'h000400, 11'd2);
      wait_drain("after_rst", 100);
      check("after_rst_beats", 32'(vid_seen), 32'd2);

      // long burst with a write becoming pending after the first beat
      vid_seen = 0;
      wr_seen = 0;
`ifdef ARB_STARVE_GUARD_EN
      cmd_strict = 1'b0;
      for (int i = 0; i < 30; i++) begin
         v.valid = 1'b1; v.done = (i == 29); v.data = mem(24'h000800 + 24'(4 * i));
         vid_q.push_back(v);
      end
`else
      expect_burst(24'h000800, 30);
      cmd_q.push_back(wrc(24'h000900, 4'b1111, 32'h13572468));
`endif
      pulse_vid(24'h000800, 11'd30);
      wait_vid(1, 50);
      raise_cyc = cyc;
      wq.push_back(wrc(24'h000900, 4'b1111, 32'h13572468));
      wait_drain("starve", 800);
      check("starve_beats", 32'(vid_seen), 32'd30);
      check("starve_wr_count", 32'(wr_seen), 32'd1);
`ifdef ARB_STARVE_GUARD_EN
      check("starve_delay_min", 32'((wr_cyc - raise_cyc) >= 64), 32'd1);
      check("starve_delay_max", 32'((wr_cyc - raise_cyc) <= 72), 32'd1);
      cmd_strict = 1'b1;
`else
      check("no_starve_wr_late", 32'((wr_cyc - raise_cyc) >= 140), 32'd1);
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #300000;
      $display("FAIL watchdog expired at t=%0t", $time);
      $fatal(1, "watchdog");
   end
endmodule
